// File: rtl/router_fifo.sv
// Per-destination packet buffer between router_reg and a router output port.
// Stores header-tagged bytes and clears data_out once a packet's parity byte is read.
module router_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PCW = WIDTH - 2;

  logic [WIDTH:0]   r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [PCW-1:0]   r_pkt_cnt;
  logic             r_lfd_d;
  logic [WIDTH-1:0] r_data_out;

  logic             w_wr_ok;
  logic             w_rd_ok;
  logic [WIDTH:0]   w_rd_word;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr_ok   = write_enb && !full  && !soft_reset;
  assign w_rd_ok   = read_enb  && !empty && !soft_reset;
  assign w_rd_word = r_mem[r_rd_ptr[AW-1:0]];
  assign data_out  = r_data_out;

  // router_reg's dout trails lfd_state by one cycle, so the tag is delayed to match.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_lfd_d <= 1'b0;
    else         r_lfd_d <= lfd_state;
  end

  always_ff @(posedge clock) begin
    if (w_wr_ok) r_mem[r_wr_ptr[AW-1:0]] <= {r_lfd_d, data_in};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (soft_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Header loads payload length + 1 so the count reaches zero on the parity read.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pkt_cnt  <= '0;
      r_data_out <= '0;
    end else if (soft_reset) begin
      r_pkt_cnt  <= '0;
      r_data_out <= '0;
    end else if (w_rd_ok) begin
      r_data_out <= w_rd_word[WIDTH-1:0];
      if (w_rd_word[WIDTH])
        r_pkt_cnt <= w_rd_word[WIDTH-1:2] + PCW'(1);
      else if (r_pkt_cnt != '0)
        r_pkt_cnt <= r_pkt_cnt - PCW'(1);
    end else if (r_pkt_cnt == '0) begin
      r_data_out <= '0;
    end
  end

endmodule
